// File: rtl/cluster_interconnect.sv
// Shared-bus fabric: NUM_CORES cores to one global memory and a device window.
// One access per cycle; reads return one cycle later on a per-core strobe.
module cluster_interconnect #(
  parameter int NUM_CORES      = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int GMEM_SIZE      = 1024,
  parameter int DEV_ADDR_WIDTH = 10,
  parameter int ARB_MODE       = 0,
  parameter int MAX_HOLD       = 4,
  localparam int GMEM_AW = $clog2(GMEM_SIZE),
  localparam int IW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            core_request,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_CORES-1:0]            core_wren,
  input  logic [NUM_CORES-1:0]            core_rden,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_write_val,
  output logic [NUM_CORES-1:0]            core_grant,
  output logic [NUM_CORES-1:0]            core_read_valid,
  output logic [DATA_WIDTH-1:0]           shared_read_val,
  output logic [IW-1:0]                   device_core_id,
  output logic                            device_write_en,
  output logic                            device_read_en,
  output logic [DEV_ADDR_WIDTH-1:0]       device_addr,
  output logic [DATA_WIDTH-1:0]           device_data_out,
  input  logic [DATA_WIDTH-1:0]           device_data_in
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [NUM_CORES-1:0] GNT_RST =
    (ARB_MODE == 1) ? NUM_CORES'(1) : '0;

  logic [NUM_CORES-1:0]  grant_q, grant_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [NUM_CORES-1:0]  rv_q;
  logic                  rdev_q;
  logic [DATA_WIDTH-1:0] mrd_q;
  logic [DATA_WIDTH-1:0] mem_q [GMEM_SIZE];

  logic [IW-1:0]         sel;
  logic [IW-1:0]         start;
  logic [IW-1:0]         idx;
  logic                  found;
  logic                  gnt_any;
  logic                  act;
  logic                  wr;
  logic                  rd;
  logic                  is_dev;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [GMEM_AW-1:0]    maddr;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (grant_q[i]) sel = IW'(i);
  end

  assign gnt_any = |grant_q;
  assign act     = grant_q[sel] & core_request[sel];
  assign addr_s  = core_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata_s = core_write_val[sel*DATA_WIDTH +: DATA_WIDTH];
  assign is_dev  = &addr_s[ADDR_WIDTH-1:DEV_ADDR_WIDTH];
  assign maddr   = addr_s[GMEM_AW-1:0];
  // Write wins when both strobes are set
  assign wr = act & core_wren[sel];
  assign rd = act & core_rden[sel] & ~core_wren[sel];

  always_comb begin
    grant_d = grant_q;
    hold_d  = hold_q;
    found   = 1'b0;
    idx     = '0;
    start   = gnt_any ? sel : IW'(NUM_CORES - 1);
    if (ARB_MODE == 1) begin
      grant_d = {grant_q[NUM_CORES-2:0], grant_q[NUM_CORES-1]};
    end else if (gnt_any && core_request[sel] &&
                 (int'(hold_q) < MAX_HOLD - 1)) begin
      hold_d = hold_q + 1'b1;
    end else begin
      grant_d = '0;
      hold_d  = '0;
      // Circular search starting after the holder; k=N revisits the holder
      for (int k = 1; k <= NUM_CORES; k++) begin
        idx = IW'((int'(start) + k) % NUM_CORES);
        if (!found && core_request[idx]) begin
          found        = 1'b1;
          grant_d[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q <= GNT_RST;
      hold_q  <= '0;
      rv_q    <= '0;
      rdev_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      hold_q  <= hold_d;
      rv_q    <= rd ? grant_q : '0;
      rdev_q  <= rd & is_dev;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !is_dev) mem_q[maddr] <= wdata_s;
    if (rd && !is_dev) mrd_q <= mem_q[maddr];
  end

  assign core_grant      = grant_q;
  assign core_read_valid = rv_q;
  assign shared_read_val = rdev_q ? device_data_in : mrd_q;
  assign device_core_id  = sel;
  assign device_write_en = wr & is_dev;
  assign device_read_en  = rd & is_dev;
  assign device_addr     = addr_s[DEV_ADDR_WIDTH-1:0];
  assign device_data_out = wdata_s;

endmodule

// File: tb/tb_cluster_interconnect.sv
// Directed bench for cluster_interconnect.
// Two instances: round-robin (mode 0) and static rotation (mode 1).
module tb_cluster_interconnect;

  localparam int N  = 16;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]  wren;
  logic [N-1:0]  rden;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] din;

  logic [N-1:0]  rr_gnt, rr_rv, ro_gnt, ro_rv;
  logic [DW-1:0] rr_rdata, ro_rdata;
  logic [3:0]    rr_id, ro_id;
  logic          rr_dwe, rr_dre, ro_dwe, ro_dre;
  logic [9:0]    rr_daddr, ro_daddr;
  logic [DW-1:0] rr_dout, ro_dout;

  int n_tests = 0;
  int n_fail  = 0;

  cluster_interconnect #(.ARB_MODE(0)) u_rr (
    .clk(clk), .reset(reset),
    .core_request(req), .core_addr(addr),
    .core_wren(wren), .core_rden(rden),
    .core_write_val(wdata),
    .core_grant(rr_gnt), .core_read_valid(rr_rv),
    .shared_read_val(rr_rdata),
    .device_core_id(rr_id),
    .device_write_en(rr_dwe), .device_read_en(rr_dre),
    .device_addr(rr_daddr), .device_data_out(rr_dout),
    .device_data_in(din)
  );

  cluster_interconnect #(.ARB_MODE(1)) u_rot (
    .clk(clk), .reset(reset),
    .core_request(req), .core_addr(addr),
    .core_wren(wren), .core_rden(rden),
    .core_write_val(wdata),
    .core_grant(ro_gnt), .core_read_valid(ro_rv),
    .shared_read_val(ro_rdata),
    .device_core_id(ro_id),
    .device_write_en(ro_dwe), .device_read_en(ro_dre),
    .device_addr(ro_daddr), .device_data_out(ro_dout),
    .device_data_in(din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int c,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    addr[c*AW +: AW]  = a;
    wdata[c*DW +: DW] = d;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    wren  = '0;
    rden  = '0;
    addr  = '0;
    wdata = '0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(rr_gnt), 32'h0);
    check("rst_rv", 32'(rr_rv), 32'h0);
    check("rst_rot_gnt", 32'(ro_gnt), 32'h1);
    check("rst_dwe", 32'(rr_dwe), 32'h0);

    // Sole requester is re-granted every cycle
    reset = 1'b1;
    req   = 16'h0008;
    tick();
    for (int c = 0; c < 6; c++) begin
      check("solo_gnt", 32'(rr_gnt), 32'h0008);
      check("solo_id", 32'(rr_id), 32'h3);
      tick();
    end
    req = '0;
    tick();
    check("idle_gnt", 32'(rr_gnt), 32'h0);

    // Two requesters alternate in blocks of MAX_HOLD
    req = 16'h0022;
    for (int c = 0; c < 16; c++) begin
      tick();
      check("rr_pair", 32'(rr_gnt),
            ((c / 4) % 2 == 0) ? 32'h0002 : 32'h0020);
    end
    req = '0;
    tick();

    // Memory write, read back, and aliased read
    req = 16'h0004;
    tick();
    set_core(2, 16'h0010, 16'hBEEF);
    wren = 16'h0004;
    #1;
    check("mem_wr_nodev", 32'(rr_dwe), 32'h0);
    tick();
    wren = '0;
    rden = 16'h0004;
    #1;
    check("mem_rd_nodev", 32'(rr_dre), 32'h0);
    tick();
    check("mem_rv", 32'(rr_rv), 32'h0004);
    check("mem_rdata", 32'(rr_rdata), 32'hBEEF);
    set_core(2, 16'h0410, 16'h0);
    tick();
    check("alias_rv", 32'(rr_rv), 32'h0004);
    check("alias_rdata", 32'(rr_rdata), 32'hBEEF);
    rden = '0;
    req  = '0;
    tick();

    // Device read by core 7; memory word 5 must survive
    req = 16'h0080;
    tick();
    set_core(7, 16'h0005, 16'hAAAA);
    wren = 16'h0080;
    tick();
    wren = '0;
    rden = 16'h0080;
    set_core(7, 16'hFC05, 16'h0);
    din = 16'h1234;
    #1;
    check("dev_dre", 32'(rr_dre), 32'h1);
    check("dev_dwe", 32'(rr_dwe), 32'h0);
    check("dev_addr", 32'(rr_daddr), 32'h5);
    check("dev_id", 32'(rr_id), 32'h7);
    tick();
    check("dev_rv", 32'(rr_rv), 32'h0080);
    check("dev_rdata", 32'(rr_rdata), 32'h1234);
    din = '0;
    set_core(7, 16'h0005, 16'h0);
    tick();
    check("mem5_rv", 32'(rr_rv), 32'h0080);
    check("mem5_rdata", 32'(rr_rdata), 32'hAAAA);
    rden = '0;
    req  = '0;
    tick();

    // Static rotation ignores requests
    reset = 1'b0;
    #1;
    check("rot_rst", 32'(ro_gnt), 32'h1);
    tick();
    reset = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      check("rot_walk", 32'(ro_gnt), 32'h1 << (c % 16));
    end
    req  = '1;
    wren = '1;
    rden = '1;
    for (int c = 0; c < N; c++) set_core(c, 16'hFC00, 16'h5A5A);
    #1;
    check("wr_rd_dwe", 32'(ro_dwe), 32'h1);
    check("wr_rd_dre", 32'(ro_dre), 32'h0);
    tick();
    check("wr_rd_rv", 32'(ro_rv), 32'h0);
    req  = '0;
    wren = '0;
    rden = '0;
    tick();
    tick();

    // Reset during a pending device read
    req  = 16'h0004;
    rden = 16'h0004;
    set_core(2, 16'hFC05, 16'h0);
    tick();
    check("pend_dre", 32'(rr_dre), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_gnt", 32'(rr_gnt), 32'h0);
    check("mid_dre", 32'(rr_dre), 32'h0);
    tick();
    check("mid_rv", 32'(rr_rv), 32'h0);
    check("mid_dre2", 32'(rr_dre), 32'h0);
    check("mid_dwe", 32'(rr_dwe), 32'h0);
    reset = 1'b1;
    tick();
    check("rel_gnt", 32'(rr_gnt), 32'h0004);
    req  = '0;
    rden = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
